// File: rtl/snake_body_queue.sv
// Snake body store: circular buffer of position words with a head pointer
// and length counter, a registered logical read port and a collision scan.
module snake_body_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 250,
  parameter int PTR_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             move,
  input  logic             grow,
  input  logic [WIDTH-1:0] head_in,
  input  logic [PTR_W-1:0] rd_index,
  output logic [WIDTH-1:0] rd_data,
  output logic [LEN_W-1:0] length,
  output logic             empty,
  output logic             full,
  output logic             move_err,
  output logic             grow_sat,
  input  logic             chk_start,
  input  logic [WIDTH-1:0] chk_pos,
  output logic             chk_busy,
  output logic             chk_done,
  output logic             chk_hit
);

  localparam int PW1 = PTR_W + 1;
  localparam int CW  = (PTR_W > LEN_W ? PTR_W : LEN_W) + 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PW1-1:0]   DEP_P = PW1'(DEPTH);
  localparam logic [LEN_W-1:0] DEP_L = LEN_W'(DEPTH);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} st_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  st_e              state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, head_nxt;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] clen_q, clen_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sat_q, sat_d;
  logic             accept, match;

  // (h - i) mod DEPTH without power-of-two wrap; valid for h, i < DEPTH
  function automatic logic [PTR_W-1:0] phys(
    input logic [PTR_W-1:0] h,
    input logic [PTR_W-1:0] i
  );
    logic [PW1-1:0] s;
    s = {1'b0, h} + DEP_P - {1'b0, i};
    if (s >= DEP_P) s = s - DEP_P;
    return s[PTR_W-1:0];
  endfunction

  assign accept   = move && (state_q == IDLE) && !chk_start;
  assign head_nxt = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
  assign match    = (mem_q[phys(head_q, PTR_W'(cnt_q))] == pos_q);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    clen_d  = clen_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sat_d   = 1'b0;
    rd_d    = '0;

    if (CW'(rd_index) < CW'(len_q))
      rd_d = mem_q[phys(head_q, rd_index)];

    if (move && !accept) err_d = 1'b1;

    if (accept) begin
      head_d = head_nxt;
      if (grow && len_q == DEP_L) sat_d = 1'b1;
      else if (grow || len_q == '0) len_d = len_q + LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (chk_start) begin
          hit_d = 1'b0;
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            pos_d   = chk_pos;
            clen_d  = len_q;
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (match || cnt_q == clen_q - LEN_W'(1)) begin
          hit_d   = match;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      clen_q  <= '0;
      pos_q   <= '0;
      rd_q    <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      clen_q  <= clen_d;
      pos_q   <= pos_d;
      rd_q    <= rd_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  // Storage is never cleared; only the pointer/length define validity
  always_ff @(posedge clock) begin
    if (reset && accept) mem_q[head_nxt] <= head_in;
  end

  assign rd_data  = rd_q;
  assign length   = len_q;
  assign empty    = (len_q == '0);
  assign full     = (len_q == DEP_L);
  assign move_err = err_q;
  assign grow_sat = sat_q;
  assign chk_busy = (state_q == SCAN);
  assign chk_done = done_q;
  assign chk_hit  = hit_q;

endmodule

// File: tb/tb_snake_body_queue.sv
// Bench for snake_body_queue: vector table, corner sequences and a
// random phase against a queue-based model of the snake body.
module tb_snake_body_queue;
  localparam int DEPTH = 250;

  logic        clock = 1'b0;
  logic        reset;
  logic        move, grow, chk_start;
  logic [31:0] head_in, chk_pos, rd_data;
  logic [7:0]  rd_index, length;
  logic        empty, full, move_err, grow_sat;
  logic        chk_busy, chk_done, chk_hit;

  int checks = 0;
  int passed = 0;
  logic [31:0] mq[$];

  always #5 clock = ~clock;

  snake_body_queue dut (
    .clock(clock), .reset(reset), .move(move), .grow(grow),
    .head_in(head_in), .rd_index(rd_index), .rd_data(rd_data),
    .length(length), .empty(empty), .full(full),
    .move_err(move_err), .grow_sat(grow_sat),
    .chk_start(chk_start), .chk_pos(chk_pos), .chk_busy(chk_busy),
    .chk_done(chk_done), .chk_hit(chk_hit)
  );

  typedef struct {
    logic        mv;
    logic        gr;
    logic [31:0] hin;
    int          idx;
    int          elen;
    logic [31:0] erd;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mread(input int i);
    return (i < mq.size()) ? mq[i] : 32'h0;
  endfunction

  task automatic mmove(input logic g, input logic [31:0] v,
                       output logic sat);
    int p;
    p = mq.size();
    sat = g && (p == DEPTH);
    mq.push_front(v);
    if ((!g && p > 0) || sat) void'(mq.pop_back());
  endtask

  task automatic do_cycle(input logic mv, input logic g,
                          input logic [31:0] v, input int idx,
                          input string tag);
    logic [31:0] erd;
    logic        sat;
    sat = 1'b0;
    erd = mread(idx);
    move = mv; grow = g; head_in = v; rd_index = 8'(idx);
    step();
    move = 1'b0;
    if (mv) mmove(g, v, sat);
    check({tag, " len"}, 32'(length), 32'(mq.size()));
    check({tag, " rd"}, rd_data, erd);
    check({tag, " err"}, 32'(move_err), 32'h0);
    check({tag, " sat"}, 32'(grow_sat), 32'(sat));
    check({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
    check({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    mq.delete();
  endtask

  task automatic run_scan(input logic [31:0] pos, input string tag);
    int n, k, edges;
    logic eh;
    n = mq.size();
    k = n - 1;
    eh = 1'b0;
    for (int i = 0; i < n; i++)
      if (!eh && mq[i] == pos) begin k = i; eh = 1'b1; end
    chk_start = 1'b1; chk_pos = pos;
    step();
    chk_start = 1'b0;
    if (n == 0) begin
      check({tag, " done0"}, 32'(chk_done), 32'h1);
      check({tag, " hit0"}, 32'(chk_hit), 32'h0);
      check({tag, " busy0"}, 32'(chk_busy), 32'h0);
      return;
    end
    check({tag, " busy"}, 32'(chk_busy), 32'h1);
    check({tag, " hitclr"}, 32'(chk_hit), 32'h0);
    edges = 0;
    while (chk_done !== 1'b1 && edges < DEPTH + 4) begin
      step();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(k + 1));
    check({tag, " hit"}, 32'(chk_hit), 32'(eh));
    check({tag, " busyend"}, 32'(chk_busy), 32'h0);
    step();
    check({tag, " donepulse"}, 32'(chk_done), 32'h0);
    check({tag, " hithold"}, 32'(chk_hit), 32'(eh));
  endtask

  vec_t vt[12];

  initial begin
    logic sat;
    reset = 1'b0; move = 1'b0; grow = 1'b0; head_in = '0;
    rd_index = '0; chk_start = 1'b0; chk_pos = '0;

    vt[0]  = '{1, 1, 32'h10, 0, 1, 32'h0};
    vt[1]  = '{1, 1, 32'h11, 0, 2, 32'h10};
    vt[2]  = '{1, 1, 32'h12, 0, 3, 32'h11};
    vt[3]  = '{0, 0, 32'h0,  0, 3, 32'h12};
    vt[4]  = '{0, 0, 32'h0,  1, 3, 32'h11};
    vt[5]  = '{0, 0, 32'h0,  2, 3, 32'h10};
    vt[6]  = '{0, 0, 32'h0,  3, 3, 32'h0};
    vt[7]  = '{1, 0, 32'h13, 0, 3, 32'h12};
    vt[8]  = '{0, 0, 32'h0,  0, 3, 32'h13};
    vt[9]  = '{0, 0, 32'h0,  1, 3, 32'h12};
    vt[10] = '{0, 0, 32'h0,  2, 3, 32'h11};
    vt[11] = '{0, 0, 32'h0,  3, 3, 32'h0};

    do_reset();
    check("rst len", 32'(length), 32'h0);
    check("rst empty", 32'(empty), 32'h1);
    check("rst full", 32'(full), 32'h0);
    check("rst rd", rd_data, 32'h0);
    check("rst busy", 32'(chk_busy), 32'h0);
    check("rst done", 32'(chk_done), 32'h0);
    check("rst hit", 32'(chk_hit), 32'h0);
    check("rst err", 32'(move_err), 32'h0);
    check("rst sat", 32'(grow_sat), 32'h0);

    for (int i = 0; i < 12; i++) begin
      move = vt[i].mv; grow = vt[i].gr; head_in = vt[i].hin;
      rd_index = 8'(vt[i].idx);
      step();
      move = 1'b0;
      if (vt[i].mv) mmove(vt[i].gr, vt[i].hin, sat);
      check($sformatf("vec%0d len", i), 32'(length), 32'(vt[i].elen));
      check($sformatf("vec%0d rd", i), rd_data, vt[i].erd);
      check($sformatf("vec%0d err", i), 32'(move_err), 32'h0);
    end

    run_scan(32'h12, "scan hit");
    run_scan(32'h55, "scan miss");

    chk_start = 1'b1; chk_pos = 32'h55;
    step();
    chk_start = 1'b0;
    move = 1'b1; grow = 1'b1; head_in = 32'hAA;
    step();
    move = 1'b0;
    check("mvscan err", 32'(move_err), 32'h1);
    check("mvscan len", 32'(length), 32'h3);
    step();
    check("mvscan errpulse", 32'(move_err), 32'h0);
    step();
    check("mvscan done", 32'(chk_done), 32'h1);
    check("mvscan hit", 32'(chk_hit), 32'h0);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, i, "mvscan rd");

    chk_start = 1'b1; chk_pos = 32'h13; move = 1'b1; head_in = 32'hBB;
    step();
    chk_start = 1'b0; move = 1'b0;
    check("mvstart err", 32'(move_err), 32'h1);
    check("mvstart busy", 32'(chk_busy), 32'h1);
    check("mvstart len", 32'(length), 32'h3);
    step();
    check("mvstart done", 32'(chk_done), 32'h1);
    check("mvstart hit", 32'(chk_hit), 32'h1);
    do_cycle(0, 0, 0, 0, "mvstart rd");

    do_reset();
    run_scan(32'h0, "scan empty");

    for (int i = 0; i < DEPTH; i++)
      do_cycle(1, 1, 32'h1000 + i, 0, "fill");
    do_cycle(1, 1, 32'hFF, 0, "sat");
    check("sat full", 32'(full), 32'h1);
    rd_index = 8'd249;
    step();
    check("sat idx249", rd_data, 32'h1001);
    do_cycle(0, 0, 0, 0, "sat head");
    check("sat head0", rd_data, 32'hFF);

    for (int c = 0; c < 800; c++) begin
      int idx;
      idx = $urandom_range(0, mq.size() + 2);
      if (idx > 255) idx = 255;
      if (c % 100 == 50) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
          run_scan(mq[$urandom_range(0, mq.size() - 1)], "rscan");
        else
          run_scan($urandom, "rscan");
      end
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, idx, "rand");
    end

    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(1, 1, 32'h20 + i, 0, "pre");
    chk_start = 1'b1; chk_pos = 32'hDEAD0000;
    step();
    chk_start = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    mq.delete();
    check("abort len", 32'(length), 32'h0);
    check("abort busy", 32'(chk_busy), 32'h0);
    check("abort done", 32'(chk_done), 32'h0);
    check("abort hit", 32'(chk_hit), 32'h0);
    step();
    check("abort nodone", 32'(chk_done), 32'h0);
    check("abort idle", 32'(chk_busy), 32'h0);
    do_cycle(1, 1, 32'h77, 0, "post");
    do_cycle(0, 0, 0, 0, "post rd");
    check("post head", rd_data, 32'h77);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/snake_body_queue.md
Name: snake_body_queue

Overview:
- Parametrised circular buffer holding the snake body as packed position words (default 32-bit), replacing the fixed 250-entry indexed register bank.
- Head pushes and tail pops are implied by a head pointer and a length counter, so a game-tick move costs one cycle instead of rewriting every segment.
- Adds a registered logical-index read port and a sequential self-collision scan used by the game-logic FSM before each move.

Parameters:
- WIDTH, 32, bits per segment position word.
- DEPTH, 250, maximum segment count; need not be a power of two.
- PTR_W, 8, physical pointer and logical index width; must satisfy 2^PTR_W >= DEPTH.
- LEN_W, 8, length counter width; must satisfy 2^LEN_W > DEPTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- move  in  1  single-cycle request to push head_in as the new head.
- grow  in  1  sampled with move; when 1, the tail is kept (length +1).
- head_in  in  WIDTH  new head position.
- rd_index  in  PTR_W  logical read index; 0 is the head and length-1 is the tail.
- rd_data  out  WIDTH  registered segment at rd_index.
- length  out  LEN_W  current segment count.
- empty  out  1  length == 0.
- full  out  1  length == DEPTH.
- move_err  out  1  one-cycle pulse when a move is rejected.
- grow_sat  out  1  one-cycle pulse when grow is requested at full.
- chk_start  in  1  starts a collision scan.
- chk_pos  in  WIDTH  position to compare; captured at chk_start.
- chk_busy  out  1  scan in progress.
- chk_done  out  1  one-cycle pulse when the scan ends.
- chk_hit  out  1  scan result; held until the next accepted chk_start.

Behaviour:
- Reset (reset==0 at an edge): length=0, head_ptr=0, rd_data=0, chk_busy=0, chk_done=0, chk_hit=0, move_err=0, grow_sat=0. Memory contents are not cleared. empty=1 and full=0 follow from length.
- Physical slot of logical index i is (head_ptr - i) mod DEPTH, computed without relying on power-of-two wrap.
- Accepted move (move=1, chk_busy=0, chk_start=0):
  - head_ptr advances as (head_ptr==DEPTH-1) ? 0 : head_ptr+1.
  - head_in is written to the new head_ptr slot.
- Length update on an accepted move:
  - grow=1 and length<DEPTH: length+1.
  - grow=1 and length==DEPTH: length unchanged (oldest segment overwritten); grow_sat pulses.
  - grow=0 and length>0: length unchanged (tail dropped implicitly).
  - grow=0 and length==0: treated as grow; length becomes 1.
- Rejected move: move=1 while chk_busy=1, or in the same cycle as chk_start. No state change; move_err pulses the next cycle.
- Read port:
  - rd_data <= (rd_index < length) ? segment[rd_index] : 0 on every edge; latency is 1 cycle.
  - The read uses pre-edge state (read-before-write), so a move in the same cycle is not visible.
- Scan FSM, states IDLE and SCAN:
  - IDLE + chk_start with length>0: capture chk_pos and the current length, cnt=0, chk_hit=0, go to SCAN.
  - IDLE + chk_start with length==0: stay in IDLE; chk_done pulses the next cycle with chk_hit=0.
  - SCAN, each cycle: compare segment[cnt] with the captured position.
    - On a match, or when cnt==captured_len-1: chk_hit<=match, chk_done pulses, return to IDLE.
    - Otherwise cnt increments.
  - chk_done therefore rises k+1 edges after the start edge, where k is the matching index, or len-1 on a miss.
  - chk_start while in SCAN is ignored.
  - chk_busy is 1 exactly while in SCAN.
- reset==0 mid-scan: the FSM aborts to IDLE, no chk_done pulse, chk_hit=0.
- All outputs are registered. empty and full are decoded from the length register.

Test Plan:
- Reset, then 3 moves with grow=1 and head_in=0x10,0x11,0x12 -> length=3; rd_index=0/1/2 gives rd_data 0x12/0x11/0x10 one cycle later; rd_index=3 gives 0.
- From that state, move with grow=0 and head_in=0x13 -> length stays 3; indices 0..2 read 0x13,0x12,0x11.
- Fill to DEPTH=250, then move with grow=1 and head_in=0xFF -> length=250, full=1, grow_sat pulses; index 249 holds the 2nd-oldest value; head_ptr wraps 249->0 correctly.
- Length 3 (0x13,0x12,0x11), chk_start with chk_pos=0x12 -> chk_busy for 2 cycles, chk_done+chk_hit=1 on the 2nd edge. With chk_pos=0x55 -> done on the 3rd edge, hit=0.
- Move during SCAN, and move together with chk_start -> move_err pulses, length and contents unchanged. chk_start at length 0 -> done next cycle, hit=0.
- Assert reset (0) mid-scan and after 5 moves -> length=0, chk_busy=0, no chk_done; the next grow-move yields length=1 with the head at index 0.
